aes_engine_sched: RTL
=====================

Name: aes_engine_sched

Overview:
- Job scheduler sitting between the AXI-facing command path and the two AES datapath engines (cipher, decipher).
- Accepts one 128-bit block job at a time via valid/ready. Dispatches it to the engine selected by the direction bit, pulsing that engine's start for one cycle.
- Muxes the single round-key SRAM read port to the active engine.
- Captures the engine result into a one-entry output buffer, presented via valid/ready.
- Watchdog aborts a hung engine.

Parameters:
- BLK_S, 128, block width in bits
- KEY_W, 128, round-key word width (ROUND_KEY_BITS)
- NB_W, 4, width of rounds_total / round_key_no fields (Nb)
- WDOG_CYCLES, 64, max cycles from engine start to engine done before abort

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- in_valid  input  1  job offered
- in_ready  output  1  scheduler can accept job
- in_block  input  BLK_S  plaintext or ciphertext
- in_decrypt  input  1  1 = decipher engine, 0 = cipher engine
- in_rounds_total  input  NB_W  10 (AES-128), 12 (AES-192) or 14 (AES-256)
- cph_en  output  1  cipher start pulse
- cph_blk  output  BLK_S  cipher input block
- cph_rounds_total  output  NB_W  rounds to cipher
- cph_round_key_no  input  NB_W  key index requested by cipher
- cph_en_o  input  1  cipher done pulse
- cph_result  input  BLK_S  cipher output
- dec_en, dec_blk, dec_rounds_total, dec_round_key_no, dec_en_o, dec_result: same as cph_* for the decipher engine
- key_addr  output  NB_W  key SRAM read address
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- out_block  output  BLK_S  result block
- out_err  output  1  qualifies out_valid: job aborted (bad rounds or watchdog)

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE, in_ready=0, cph_en=dec_en=0, out_valid=0, out_err=0, out_block=0, cph/dec_blk=0, *_rounds_total=0, key_addr=0, watchdog=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid with legal rounds_total: latch block, dir, rounds_total; go START.
    - On in_valid with rounds_total not in {10,12,14}: accept, then go DONE with out_err=1 and out_block=0; no engine started.
  - START:
    - One cycle.
    - Selected engine's en=1. Its blk and rounds_total are driven from the latches and held stable until DONE.
    - Watchdog cleared. Go RUN.
  - RUN:
    - key_addr = round_key_no of the selected engine (combinational mux); SRAM returns data next cycle directly to the engines.
    - Watchdog increments each cycle.
    - On selected engine en_o=1: capture result into out_block, out_err=0, go DONE.
    - If watchdog reaches WDOG_CYCLES-1 without en_o: out_block=0, out_err=1, go DONE.
    - en_o from the non-selected engine is ignored.
  - DONE:
    - out_valid=1; out_block and out_err stable.
    - On out_ready: out_valid=0 next cycle, go IDLE.
- in_ready is 0 in START/RUN/DONE.
- Throughput: one job per (engine latency + 3) cycles plus consumer stall.
- Latency: accept at cycle T → en at T+1 → out_valid the cycle after en_o.
- Simultaneous en_o and watchdog expiry: en_o wins, result valid, out_err=0.
- In IDLE/DONE, key_addr holds its last value (no spurious SRAM dependence).
- Reset mid-RUN: all state cleared immediately. Engines must be reset by the same reset; no result is emitted.

Test Plan:
- Decrypt AES-128: in_block=69c4e0d86a7b0430d8cdb78070b4c55a, in_decrypt=1, rounds=10, key SRAM loaded with FIPS-197 C.1 schedule → dec_en single pulse, cph_en never; out_block=00112233445566778899aabbccddeeff, out_err=0.
- Encrypt AES-256: 00112233445566778899aabbccddeeff, in_decrypt=0, rounds=14 → out_block=8ea2b7ca516745bfeafc49904b496089. key_addr tracks cph_round_key_no every RUN cycle.
- Back-to-back decrypt-128 then decrypt-256 with out_ready held low 10 cycles after the first result → out_valid and out_block stable throughout, in_ready=0 until handshake; second job result 00112233…eeff.
- in_rounds_total=11 → no engine start; out_valid=1, out_err=1, out_block=0 within 2 cycles.
- Engine stub never asserts en_o → out_err=1 exactly WDOG_CYCLES cycles after en; then a legal job completes normally.
- Assert reset low in mid-RUN → in_ready=0 and out_valid=0 during reset, no out_valid afterwards, IDLE with in_ready=1 after release.

Source files
------------

// File: rtl/aes_engine_sched.sv
// Job scheduler between the command path and the AES cipher/decipher engines.
// Dispatches one block job at a time, muxes the round-key SRAM port and buffers one result.
module aes_engine_sched #(
  parameter int unsigned BLK_S       = 128,
  parameter int unsigned KEY_W       = 128,
  parameter int unsigned NB_W        = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_S-1:0] in_block,
  input  logic             in_decrypt,
  input  logic [NB_W-1:0]  in_rounds_total,
  output logic             cph_en,
  output logic [BLK_S-1:0] cph_blk,
  output logic [NB_W-1:0]  cph_rounds_total,
  input  logic [NB_W-1:0]  cph_round_key_no,
  input  logic             cph_en_o,
  input  logic [BLK_S-1:0] cph_result,
  output logic             dec_en,
  output logic [BLK_S-1:0] dec_blk,
  output logic [NB_W-1:0]  dec_rounds_total,
  input  logic [NB_W-1:0]  dec_round_key_no,
  input  logic             dec_en_o,
  input  logic [BLK_S-1:0] dec_result,
  output logic [NB_W-1:0]  key_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_S-1:0] out_block,
  output logic             out_err
);

  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  // Round keys are XORed straight into the state, so the widths must agree.
  if (KEY_W != BLK_S) begin : g_key_w_check
    $error("KEY_W must equal BLK_S");
  end

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  state_e           state_q;
  logic             dir_q;
  logic             in_ready_q;
  logic             cph_en_q;
  logic             dec_en_q;
  logic [BLK_S-1:0] cph_blk_q;
  logic [BLK_S-1:0] dec_blk_q;
  logic [NB_W-1:0]  cph_rt_q;
  logic [NB_W-1:0]  dec_rt_q;
  logic [NB_W-1:0]  key_addr_q;
  logic [WdogW-1:0] wdog_q;
  logic [WdogW-1:0] wdog_nxt;
  logic             out_valid_q;
  logic             out_err_q;
  logic [BLK_S-1:0] out_block_q;

  logic             rounds_legal;
  logic [NB_W-1:0]  sel_key_no;
  logic             sel_done;
  logic [BLK_S-1:0] sel_result;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  assign rounds_legal = (in_rounds_total == NB_W'(10)) ||
                        (in_rounds_total == NB_W'(12)) ||
                        (in_rounds_total == NB_W'(14));

  assign sel_key_no = dir_q ? dec_round_key_no : cph_round_key_no;
  assign sel_done   = dir_q ? dec_en_o : cph_en_o;
  assign sel_result = dir_q ? dec_result : cph_result;
  assign wdog_nxt   = wdog_q + WdogW'(1);

  // Outside RUN the SRAM address is frozen so idle engines cannot disturb it.
  assign key_addr = (state_q == StRun) ? sel_key_no : key_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      cph_en_q    <= 1'b0;
      dec_en_q    <= 1'b0;
      cph_blk_q   <= '0;
      dec_blk_q   <= '0;
      cph_rt_q    <= '0;
      dec_rt_q    <= '0;
      key_addr_q  <= '0;
      wdog_q      <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_block_q <= '0;
    end else begin
      cph_en_q <= 1'b0;
      dec_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (rounds_legal) begin
              dir_q  <= in_decrypt;
              wdog_q <= '0;
              if (in_decrypt) begin
                dec_blk_q <= in_block;
                dec_rt_q  <= in_rounds_total;
                dec_en_q  <= 1'b1;
              end else begin
                cph_blk_q <= in_block;
                cph_rt_q  <= in_rounds_total;
                cph_en_q  <= 1'b1;
              end
              state_q <= StStart;
            end else begin
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_block_q <= '0;
              state_q     <= StDone;
            end
          end
        end
        StStart: begin
          wdog_q  <= '0;
          state_q <= StRun;
        end
        StRun: begin
          key_addr_q <= sel_key_no;
          wdog_q     <= wdog_nxt;
          // A done pulse in the expiry cycle still counts as a good result.
          if (sel_done) begin
            out_block_q <= sel_result;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (wdog_nxt == WdogW'(WDOG_CYCLES - 1)) begin
            out_block_q <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign cph_en           = cph_en_q;
  assign dec_en           = dec_en_q;
  assign cph_blk          = cph_blk_q;
  assign dec_blk          = dec_blk_q;
  assign cph_rounds_total = cph_rt_q;
  assign dec_rounds_total = dec_rt_q;
  assign out_valid        = out_valid_q;
  assign out_err          = out_err_q;
  assign out_block        = out_block_q;

endmodule
